// File: rtl/rv_multicycle_ctrl_if.sv
// Control and memory-handshake bundle between the multicycle sequencer and the RV32I datapath.
// master = sequencer (drives enables/selects and requests), slave = datapath/memories (IR fields, flags, acks).
interface rv_multicycle_ctrl_if;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       br_eq;
   logic       br_lt;
   logic       imem_req;
   logic       imem_ack;
   logic       dmem_req;
   logic       dmem_ack;
   logic       dmem_we;
   logic       ir_we;
   logic       pc_we;
   logic       pc_sel;
   logic       reg_wen;
   logic       brun;
   logic       a_sel;
   logic       b_sel;
   logic [1:0] alu_op;
   logic [2:0] imm_sel;
   logic [1:0] wb_sel;

   modport master (
      input  opcode, funct3, br_eq, br_lt, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_wen,
             brun, a_sel, b_sel, alu_op, imm_sel, wb_sel
   );

   modport slave (
      output opcode, funct3, br_eq, br_lt, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_wen,
             brun, a_sel, b_sel, alu_op, imm_sel, wb_sel
   );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// RV32I FETCH/DECODE/EXEC/MEM/WB sequencer; 3-5 cycles per instruction plus memory wait states, stalls on missing imem/dmem ack.
// Optional WAIT_TIMEOUT_EN: bounds each memory wait to TIMEOUT cycles and traps with a sticky timeout flag.
module rv_multicycle_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   rv_multicycle_ctrl_if.master bus,
   output logic [2:0]           state,
   output logic                 illegal,
   output logic                 timeout,
   output logic [CNT_W-1:0]     retire_cnt
);

   typedef enum logic [2:0] {
      st_fetch  = 3'd0,
      st_decode = 3'd1,
      st_exec   = 3'd2,
      st_mem    = 3'd3,
      st_wb     = 3'd4,
      st_trap   = 3'd7
   } state_t;

   localparam logic [6:0] op_r      = 7'b0110011;
   localparam logic [6:0] op_i      = 7'b0010011;
   localparam logic [6:0] op_load   = 7'b0000011;
   localparam logic [6:0] op_store  = 7'b0100011;
   localparam logic [6:0] op_branch = 7'b1100011;
   localparam logic [6:0] op_jal    = 7'b1101111;
   localparam logic [6:0] op_lui    = 7'b0110111;
   localparam logic [6:0] op_auipc  = 7'b0010111;

   if (CNT_W < 1 || TIMEOUT < 1) begin : g_param_chk
      $error("rv_multicycle_ctrl: CNT_W and TIMEOUT must be >= 1");
   end

   state_t     state_q;
   state_t     state_d;
   logic [6:0] op_q;
   logic [2:0] f3_q;
   logic       opcode_ok;
   logic       taken;
   logic       wait_hit;
   logic       alu_a;
   logic       alu_b;
   logic [1:0] alu_opc;
   logic [2:0] alu_imm;

   always_comb begin
      case (bus.opcode)
         op_r, op_i, op_load, op_store, op_branch, op_jal, op_lui, op_auipc: opcode_ok = 1'b1;
         default:                                                             opcode_ok = 1'b0;
      endcase
   end

   // Same operand/immediate encodings the single-cycle decoder emits for each opcode.
   always_comb begin
      alu_a   = 1'b0;
      alu_b   = 1'b1;
      alu_opc = 2'b00;
      alu_imm = 3'b000;
      case (op_q)
         op_r:      begin alu_b = 1'b0; alu_opc = 2'b10; end
         op_i:      alu_opc = 2'b10;
         op_store:  alu_imm = 3'b001;
         op_branch: begin alu_a = 1'b1; alu_imm = 3'b010; end
         op_jal:    begin alu_a = 1'b1; alu_imm = 3'b100; end
         op_lui:    alu_imm = 3'b011;
         op_auipc:  begin alu_a = 1'b1; alu_imm = 3'b100; end
         default:   ;
      endcase
   end

   always_comb begin
      case (f3_q)
         3'b000:         taken = bus.br_eq;
         3'b001:         taken = ~bus.br_eq;
         3'b100, 3'b110: taken = bus.br_lt;
         3'b101, 3'b111: taken = ~bus.br_lt;
         default:        taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      bus.imem_req = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_we  = 1'b0;
      bus.ir_we    = 1'b0;
      bus.pc_we    = 1'b0;
      bus.pc_sel   = 1'b0;
      bus.reg_wen  = 1'b0;
      bus.brun     = 1'b0;
      bus.a_sel    = 1'b0;
      bus.b_sel    = 1'b0;
      bus.alu_op   = 2'b00;
      bus.imm_sel  = 3'b000;
      bus.wb_sel   = 2'b00;
      case (state_q)
         st_fetch: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) begin
               bus.ir_we = 1'b1;
               state_d   = st_decode;
            end
         end
         st_decode: state_d = opcode_ok ? st_exec : st_trap;
         st_exec: begin
            bus.a_sel   = alu_a;
            bus.b_sel   = alu_b;
            bus.alu_op  = alu_opc;
            bus.imm_sel = alu_imm;
            if (op_q == op_branch) begin
               bus.brun   = f3_q[1];
               bus.pc_sel = taken;
               bus.pc_we  = 1'b1;
               state_d    = st_fetch;
            end else if (op_q == op_load || op_q == op_store) begin
               state_d = st_mem;
            end else begin
               state_d = st_wb;
            end
         end
         st_mem: begin
            // Address stays on the ALU output for the whole access.
            bus.dmem_req = 1'b1;
            bus.dmem_we  = (op_q == op_store);
            bus.a_sel    = alu_a;
            bus.b_sel    = alu_b;
            bus.alu_op   = alu_opc;
            bus.imm_sel  = alu_imm;
            if (bus.dmem_ack) begin
               if (op_q == op_store) begin
                  bus.pc_we = 1'b1;
                  state_d   = st_fetch;
               end else begin
                  state_d = st_wb;
               end
            end
         end
         st_wb: begin
            bus.reg_wen = 1'b1;
            bus.pc_we   = 1'b1;
            state_d     = st_fetch;
            if (op_q == op_load) begin
               bus.wb_sel = 2'b00;
            end else if (op_q == op_jal) begin
               bus.wb_sel  = 2'b10;
               bus.pc_sel  = 1'b1;
               bus.a_sel   = alu_a;
               bus.b_sel   = alu_b;
               bus.alu_op  = alu_opc;
               bus.imm_sel = alu_imm;
            end else begin
               bus.wb_sel = 2'b01;
            end
         end
         st_trap: ;
         default: state_d = st_trap;
      endcase
      if (wait_hit) state_d = st_trap;
      // Reset kills every request and enable immediately, including a pending store.
      if (rst) begin
         bus.imem_req = 1'b0;
         bus.dmem_req = 1'b0;
         bus.dmem_we  = 1'b0;
         bus.ir_we    = 1'b0;
         bus.pc_we    = 1'b0;
         bus.pc_sel   = 1'b0;
         bus.reg_wen  = 1'b0;
         bus.brun     = 1'b0;
         bus.a_sel    = 1'b0;
         bus.b_sel    = 1'b0;
         bus.alu_op   = 2'b00;
         bus.imm_sel  = 3'b000;
         bus.wb_sel   = 2'b00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= st_fetch;
         op_q       <= '0;
         f3_q       <= '0;
         illegal    <= 1'b0;
         retire_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == st_decode) begin
            op_q <= bus.opcode;
            f3_q <= bus.funct3;
            if (!opcode_ok) illegal <= 1'b1;
         end
         if (bus.pc_we) retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

   assign state = state_q;

`ifdef WAIT_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_q;
   logic              waiting;

   assign waiting  = (state_q == st_fetch && !bus.imem_ack) || (state_q == st_mem && !bus.dmem_ack);
   assign wait_hit = waiting && (wait_q == WAIT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_q  <= '0;
         timeout <= 1'b0;
      end else begin
         if (state_d != state_q) wait_q <= '0;
         else if (waiting)       wait_q <= wait_q + WAIT_W'(1);
         if (wait_hit) timeout <= 1'b1;
      end
   end
`else
   assign wait_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: randomized instructions checked cycle by cycle against a per-instruction trace model.
module tb_rv_multicycle_ctrl;
   localparam int CNT_W = 8;

   localparam logic [6:0] op_r      = 7'b0110011;
   localparam logic [6:0] op_i      = 7'b0010011;
   localparam logic [6:0] op_load   = 7'b0000011;
   localparam logic [6:0] op_store  = 7'b0100011;
   localparam logic [6:0] op_branch = 7'b1100011;
   localparam logic [6:0] op_jal    = 7'b1101111;
   localparam logic [6:0] op_lui    = 7'b0110111;
   localparam logic [6:0] op_auipc  = 7'b0010111;

   typedef struct packed {
      logic [2:0] state;
      logic       imem_req;
      logic       dmem_req;
      logic       dmem_we;
      logic       ir_we;
      logic       pc_we;
      logic       pc_sel;
      logic       reg_wen;
      logic       brun;
      logic       a_sel;
      logic       b_sel;
      logic [1:0] alu_op;
      logic [2:0] imm_sel;
      logic [1:0] wb_sel;
   } snap_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       state;
   logic             illegal;
   logic             timeout;
   logic [CNT_W-1:0] retire_cnt;

   int               tests  = 0;
   int               failed = 0;
   logic [CNT_W-1:0] exp_retire;
   snap_t            exp_q[$];
   snap_t            msk_q[$];
   snap_t            obs_q[$];
   logic [6:0]       legal_ops[8] = '{op_r, op_i, op_load, op_store, op_branch, op_jal, op_lui, op_auipc};

   rv_multicycle_ctrl_if bus();

   rv_multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .state      (state),
      .illegal    (illegal),
      .timeout    (timeout),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
      $fatal(1);
   end

   // {a_sel, b_sel, alu_op, imm_sel} for each opcode class.
   function automatic logic [6:0] alu_fields(input logic [6:0] op);
      case (op)
         op_r:      return {1'b0, 1'b0, 2'b10, 3'b000};
         op_i:      return {1'b0, 1'b1, 2'b10, 3'b000};
         op_load:   return {1'b0, 1'b1, 2'b00, 3'b000};
         op_store:  return {1'b0, 1'b1, 2'b00, 3'b001};
         op_branch: return {1'b1, 1'b1, 2'b00, 3'b010};
         op_jal:    return {1'b1, 1'b1, 2'b00, 3'b100};
         op_lui:    return {1'b0, 1'b1, 2'b00, 3'b011};
         op_auipc:  return {1'b1, 1'b1, 2'b00, 3'b100};
         default:   return 7'd0;
      endcase
   endfunction

   function automatic logic is_taken(input logic [2:0] f3, input logic eq, input logic lt);
      case (f3)
         3'b000:         return eq;
         3'b001:         return !eq;
         3'b100, 3'b110: return lt;
         3'b101, 3'b111: return !lt;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic snap_t sample();
      snap_t s;
      s.state    = state;
      s.imem_req = bus.imem_req;
      s.dmem_req = bus.dmem_req;
      s.dmem_we  = bus.dmem_we;
      s.ir_we    = bus.ir_we;
      s.pc_we    = bus.pc_we;
      s.pc_sel   = bus.pc_sel;
      s.reg_wen  = bus.reg_wen;
      s.brun     = bus.brun;
      s.a_sel    = bus.a_sel;
      s.b_sel    = bus.b_sel;
      s.alu_op   = bus.alu_op;
      s.imm_sel  = bus.imm_sel;
      s.wb_sel   = bus.wb_sel;
      return s;
   endfunction

   // Expected per-cycle outputs of one instruction given its memory wait states.
   task automatic build_exp(input logic [6:0] op, input logic [2:0] f3, input logic eq, input logic lt,
                            input int iw, input int dw, input int ntrap);
      snap_t s;
      snap_t m;
      bit    legal, is_br, is_ld, is_st, is_jal;
      exp_q.delete();
      msk_q.delete();
      legal  = op inside {op_r, op_i, op_load, op_store, op_branch, op_jal, op_lui, op_auipc};
      is_br  = (op == op_branch);
      is_ld  = (op == op_load);
      is_st  = (op == op_store);
      is_jal = (op == op_jal);
      m = '1;
      for (int i = 0; i <= iw; i++) begin
         s = '0; s.state = 3'd0; s.imem_req = 1'b1; s.ir_we = (i == iw);
         exp_q.push_back(s); msk_q.push_back(m);
      end
      s = '0; s.state = 3'd1;
      exp_q.push_back(s); msk_q.push_back(m);
      if (!legal) begin
         for (int i = 0; i < ntrap; i++) begin
            s = '0; s.state = 3'd7;
            exp_q.push_back(s); msk_q.push_back(m);
         end
         return;
      end
      s = '0; s.state = 3'd2;
      {s.a_sel, s.b_sel, s.alu_op, s.imm_sel} = alu_fields(op);
      if (is_br) begin
         s.brun = f3[1]; s.pc_we = 1'b1; s.pc_sel = is_taken(f3, eq, lt);
      end
      exp_q.push_back(s); msk_q.push_back(m);
      if (is_ld || is_st) begin
         for (int i = 0; i <= dw; i++) begin
            s = '0; s.state = 3'd3; s.dmem_req = 1'b1; s.dmem_we = is_st;
            {s.a_sel, s.b_sel, s.alu_op, s.imm_sel} = alu_fields(op);
            s.pc_we = is_st && (i == dw);
            exp_q.push_back(s); msk_q.push_back(m);
         end
      end
      if (!is_br && !is_st) begin
         s = '0; s.state = 3'd4; s.reg_wen = 1'b1; s.pc_we = 1'b1;
         s.wb_sel = is_ld ? 2'b00 : (is_jal ? 2'b10 : 2'b01);
         s.pc_sel = is_jal;
         if (is_jal) {s.a_sel, s.b_sel, s.alu_op, s.imm_sel} = alu_fields(op);
         else begin m.a_sel = 1'b0; m.b_sel = 1'b0; m.alu_op = 2'b00; m.imm_sel = 3'b000; end
         exp_q.push_back(s); msk_q.push_back(m);
      end
   endtask

   // Runs ncyc cycles from posedge+1; memories ack after iw/dw cycles of request.
   task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic eq, input logic lt,
                             input int iw, input int dw, input int ncyc);
      int ic = 0;
      int dc = 0;
      obs_q.delete();
      repeat (ncyc) begin
         bus.opcode   = op;
         bus.funct3   = f3;
         bus.br_eq    = eq;
         bus.br_lt    = lt;
         bus.imem_ack = bus.imem_req && (ic == iw);
         bus.dmem_ack = bus.dmem_req && (dc == dw);
         @(negedge clk);
         obs_q.push_back(sample());
         if (bus.imem_req) ic++;
         if (bus.dmem_req) dc++;
         @(posedge clk); #1;
      end
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      exp_retire = '0;
   endtask

   task automatic test_reset();
      snap_t s;
      rst = 1'b1;
      bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.br_eq = 1'b0; bus.br_lt = 1'b0;
      bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      s = sample();
      tests++; if (s !== '0) begin failed++; $display("FAIL reset_outputs: got %h want 0", s); end
      tests++; if (retire_cnt !== '0) begin failed++; $display("FAIL reset_retire: got %0d want 0", retire_cnt); end
      tests++; if (illegal !== 1'b0) begin failed++; $display("FAIL reset_illegal: got %b want 0", illegal); end
      tests++; if (timeout !== 1'b0) begin failed++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      rst = 1'b0;
      #1;
      tests++; if (state !== 3'd0 || bus.imem_req !== 1'b1) begin
         failed++; $display("FAIL reset_release: state %0d imem_req %b, want 0/1", state, bus.imem_req);
      end
      @(posedge clk); #1;
      exp_retire = '0;
   endtask

   task automatic test_add();
      build_exp(op_r, 3'b000, 1'b0, 1'b0, 0, 0, 0);
      exec_instr(op_r, 3'b000, 1'b0, 1'b0, 0, 0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++; if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failed++; $display("FAIL add cyc%0d: got %h want %h mask %h", i, obs_q[i], exp_q[i], msk_q[i]);
         end
      end
      exp_retire++;
      tests++; if (state !== 3'd0) begin failed++; $display("FAIL add_next_state: got %0d want 0", state); end
      tests++; if (retire_cnt !== exp_retire) begin failed++; $display("FAIL add_retire: got %0d want %0d", retire_cnt, exp_retire); end
   endtask

   task automatic test_load();
      build_exp(op_load, 3'b010, 1'b0, 1'b0, 0, 3, 0);
      exec_instr(op_load, 3'b010, 1'b0, 1'b0, 0, 3, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++; if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failed++; $display("FAIL lw_wait cyc%0d: got %h want %h mask %h", i, obs_q[i], exp_q[i], msk_q[i]);
         end
      end
      exp_retire++;
      tests++; if (state !== 3'd0) begin failed++; $display("FAIL lw_next_state: got %0d want 0", state); end
      tests++; if (retire_cnt !== exp_retire) begin failed++; $display("FAIL lw_retire: got %0d want %0d", retire_cnt, exp_retire); end
   endtask

   task automatic test_branch();
      logic [4:0] tbl[4] = '{{3'b000, 1'b1, 1'b0}, {3'b000, 1'b0, 1'b0}, {3'b110, 1'b0, 1'b1}, {3'b101, 1'b0, 1'b0}};
      for (int k = 0; k < 4; k++) begin
         logic [4:0] e = tbl[k];
         build_exp(op_branch, e[4:2], e[1], e[0], 0, 0, 0);
         exec_instr(op_branch, e[4:2], e[1], e[0], 0, 0, exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            tests++; if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
               failed++; $display("FAIL branch%0d cyc%0d: got %h want %h", k, i, obs_q[i], exp_q[i]);
            end
         end
         exp_retire++;
         tests++; if (state !== 3'd0 || retire_cnt !== exp_retire) begin
            failed++; $display("FAIL branch%0d_end: state %0d retire %0d, want 0/%0d", k, state, retire_cnt, exp_retire);
         end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++) begin
         logic [6:0] op = legal_ops[$urandom_range(0, 7)];
         logic [2:0] f3 = 3'($urandom_range(0, 7));
         logic       eq = 1'($urandom_range(0, 1));
         logic       lt = 1'($urandom_range(0, 1));
         int         iw = $urandom_range(0, 3);
         int         dw = $urandom_range(0, 3);
         build_exp(op, f3, eq, lt, iw, dw, 0);
         exec_instr(op, f3, eq, lt, iw, dw, exp_q.size());
         for (int i = 0; i < exp_q.size(); i++) begin
            tests++; if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
               failed++; $display("FAIL rand%0d op %b f3 %b cyc%0d: got %h want %h", k, op, f3, i, obs_q[i], exp_q[i]);
            end
         end
         exp_retire++;
         tests++; if (state !== 3'd0 || retire_cnt !== exp_retire) begin
            failed++; $display("FAIL rand%0d_end: state %0d retire %0d, want 0/%0d", k, state, retire_cnt, exp_retire);
         end
      end
   endtask

   task automatic test_wrap();
      bit wrapped = 0;
      for (int k = 0; k < 300 && !wrapped; k++) begin
         build_exp(op_branch, 3'b001, 1'b0, 1'b0, 0, 0, 0);
         exec_instr(op_branch, 3'b001, 1'b0, 1'b0, 0, 0, exp_q.size());
         exp_retire++;
         tests++; if (retire_cnt !== exp_retire) begin
            failed++; $display("FAIL wrap_retire: got %0d want %0d", retire_cnt, exp_retire);
         end
         if (exp_retire == '0) wrapped = 1;
      end
      build_exp(op_lui, 3'b000, 1'b0, 1'b0, 0, 0, 0);
      exec_instr(op_lui, 3'b000, 1'b0, 1'b0, 0, 0, exp_q.size());
      exp_retire++;
      tests++; if (retire_cnt !== exp_retire) begin
         failed++; $display("FAIL wrap_after: got %0d want %0d", retire_cnt, exp_retire);
      end
   endtask

   task automatic test_illegal();
      build_exp(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, 10);
      exec_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++; if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failed++; $display("FAIL illegal cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      tests++; if (illegal !== 1'b1) begin failed++; $display("FAIL illegal_flag: got %b want 1", illegal); end
      tests++; if (retire_cnt !== exp_retire) begin failed++; $display("FAIL illegal_retire: got %0d want %0d", retire_cnt, exp_retire); end
      #2 rst = 1'b1;
      #1;
      tests++; if (state !== 3'd0 || illegal !== 1'b0 || bus.imem_req !== 1'b0) begin
         failed++; $display("FAIL illegal_rst: state %0d illegal %b imem_req %b, want 0/0/0", state, illegal, bus.imem_req);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      exp_retire = '0;
      tests++; if (state !== 3'd0 || bus.imem_req !== 1'b1) begin
         failed++; $display("FAIL illegal_restart: state %0d imem_req %b, want 0/1", state, bus.imem_req);
      end
   endtask

   task automatic test_timeout();
      int nfetch = 0;
      do_reset();
`ifdef WAIT_TIMEOUT_EN
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (state !== 3'd0) break;
         nfetch++;
         @(posedge clk); #1;
      end
      tests++; if (nfetch !== 4) begin failed++; $display("FAIL timeout_cycles: got %0d fetch cycles want 4", nfetch); end
      tests++; if (state !== 3'd7 || timeout !== 1'b1) begin
         failed++; $display("FAIL timeout_trap: state %0d timeout %b, want 7/1", state, timeout);
      end
      tests++; if (bus.imem_req !== 1'b0) begin failed++; $display("FAIL timeout_req: got %b want 0", bus.imem_req); end
`else
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (state === 3'd0) nfetch++;
         @(posedge clk); #1;
      end
      tests++; if (nfetch !== 100) begin failed++; $display("FAIL no_timeout_cycles: got %0d fetch cycles want 100", nfetch); end
      tests++; if (state !== 3'd0 || bus.imem_req !== 1'b1 || timeout !== 1'b0) begin
         failed++; $display("FAIL no_timeout_state: state %0d req %b timeout %b, want 0/1/0", state, bus.imem_req, timeout);
      end
`endif
      do_reset();
   endtask

   task automatic test_reset_mid_mem();
      build_exp(op_auipc, 3'b000, 1'b0, 1'b0, 0, 0, 0);
      exec_instr(op_auipc, 3'b000, 1'b0, 1'b0, 0, 0, exp_q.size());
      exp_retire++;
      exec_instr(op_store, 3'b010, 1'b0, 1'b0, 0, 20, 6);
      tests++; if (state !== 3'd3 || bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
         failed++; $display("FAIL midmem_pre: state %0d req %b we %b, want 3/1/1", state, bus.dmem_req, bus.dmem_we);
      end
      tests++; if (retire_cnt !== exp_retire) begin failed++; $display("FAIL midmem_retire: got %0d want %0d", retire_cnt, exp_retire); end
      #2 rst = 1'b1;
      #1;
      tests++; if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.pc_we !== 1'b0 || state !== 3'd0) begin
         failed++; $display("FAIL midmem_rst: req %b we %b pc_we %b state %0d, want 0/0/0/0",
                            bus.dmem_req, bus.dmem_we, bus.pc_we, state);
      end
      @(posedge clk);
      @(negedge clk);
      tests++; if (retire_cnt !== '0) begin failed++; $display("FAIL midmem_count: got %0d want 0", retire_cnt); end
      rst = 1'b0;
      @(posedge clk); #1;
      exp_retire = '0;
      build_exp(op_jal, 3'b000, 1'b0, 1'b0, 1, 0, 0);
      exec_instr(op_jal, 3'b000, 1'b0, 1'b0, 1, 0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         tests++; if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
            failed++; $display("FAIL post_rst_jal cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      exp_retire++;
      tests++; if (retire_cnt !== exp_retire) begin failed++; $display("FAIL post_rst_retire: got %0d want %0d", retire_cnt, exp_retire); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load();
      test_branch();
      test_random();
      test_wrap();
      test_illegal();
      test_timeout();
      test_reset_mid_mem();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
